// File: rtl/exec_unit.sv
// Multi-cycle execute stage: ALU ops in one cycle, shifts one bit per cycle,
// shift-add multiply one partial product per cycle, then a one-cycle write-back.
module exec_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [4:0]       dest_addr,
    output logic             busy,
    output logic             RegWrite,
    output logic [4:0]       reg_write_addr,
    output logic [WIDTH-1:0] write_data,
    output logic             carry,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned CNT_W = 6;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_WB} state_t;

    state_t           state, state_n;
    logic [3:0]       op_q, op_n;
    logic [WIDTH-1:0] work, work_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] count, count_n;
    logic             ill_q, ill_n;
    logic             busy_n, reg_write_n, illegal_n, carry_n, zero_n;
    logic [4:0]       addr_n;
    logic [WIDTH-1:0] wd_n;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] sh_val, mul_sum;
    logic             sh_out;

    // SUB uses op1 + ~op2 + 1 so carry-out means "no borrow"
    assign add_sum = {1'b0, op1} + {1'b0, op2};
    assign sub_sum = {1'b0, op1} + {1'b0, ~op2} + (WIDTH+1)'(1);
    assign mul_sum = acc + (mplier[0] ? work : '0);

    // One-bit step of the working shift value and the bit it pushes out
    always_comb begin
        sh_val = work;
        sh_out = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_val = {work[WIDTH-2:0], 1'b0};
                sh_out = work[WIDTH-1];
            end
            OP_SRL: begin
                sh_val = {1'b0, work[WIDTH-1:1]};
                sh_out = work[0];
            end
            OP_SRA: begin
                sh_val = {work[WIDTH-1], work[WIDTH-1:1]};
                sh_out = work[0];
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        work_n   = work;
        mplier_n = mplier;
        acc_n    = acc;
        count_n  = count;
        ill_n    = ill_q;
        addr_n   = reg_write_addr;
        wd_n     = write_data;
        carry_n  = carry;
        zero_n   = zero;

        case (state)
            S_IDLE: begin
                if (start) begin
                    op_n   = alu_op;
                    addr_n = dest_addr;
                    ill_n  = 1'b0;
                    case (alu_op)
                        OP_ADD: begin
                            wd_n    = add_sum[WIDTH-1:0];
                            carry_n = add_sum[WIDTH];
                            state_n = S_WB;
                        end
                        OP_SUB: begin
                            wd_n    = sub_sum[WIDTH-1:0];
                            carry_n = sub_sum[WIDTH];
                            state_n = S_WB;
                        end
                        OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                            case (alu_op)
                                OP_AND:  wd_n = op1 & op2;
                                OP_OR:   wd_n = op1 | op2;
                                OP_XOR:  wd_n = op1 ^ op2;
                                default: wd_n = ~op1;
                            endcase
                            carry_n = 1'b0;
                            state_n = S_WB;
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (op2[4:0] == 5'd0) begin
                                wd_n    = op1;
                                carry_n = 1'b0;
                                state_n = S_WB;
                            end else begin
                                work_n  = op1;
                                count_n = CNT_W'(op2[4:0]);
                                state_n = S_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            acc_n    = '0;
                            work_n   = op1;
                            mplier_n = op2;
                            count_n  = CNT_W'(MUL_CYCLES);
                            state_n  = S_MUL;
                        end
                        default: begin
                            ill_n   = 1'b1;
                            state_n = S_WB;
                        end
                    endcase
                    if (state_n == S_WB && !ill_n) begin
                        zero_n = (wd_n == '0);
                    end
                end
            end
            S_SHIFT: begin
                work_n  = sh_val;
                count_n = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    wd_n    = sh_val;
                    carry_n = sh_out;
                    zero_n  = (sh_val == '0);
                    state_n = S_WB;
                end
            end
            S_MUL: begin
                acc_n    = mul_sum;
                work_n   = {work[WIDTH-2:0], 1'b0};
                mplier_n = {1'b0, mplier[WIDTH-1:1]};
                count_n  = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    wd_n    = mul_sum;
                    carry_n = 1'b0;
                    zero_n  = (mul_sum == '0);
                    state_n = S_WB;
                end
            end
            default: begin
                ill_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        busy_n      = (state_n != S_IDLE);
        reg_write_n = (state_n == S_WB) && !ill_n;
        illegal_n   = (state_n == S_WB) && ill_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            op_q           <= '0;
            work           <= '0;
            mplier         <= '0;
            acc            <= '0;
            count          <= '0;
            ill_q          <= 1'b0;
            busy           <= 1'b0;
            RegWrite       <= 1'b0;
            illegal        <= 1'b0;
            reg_write_addr <= '0;
            write_data     <= '0;
            carry          <= 1'b0;
            zero           <= 1'b0;
        end else begin
            state          <= state_n;
            op_q           <= op_n;
            work           <= work_n;
            mplier         <= mplier_n;
            acc            <= acc_n;
            count          <= count_n;
            ill_q          <= ill_n;
            busy           <= busy_n;
            RegWrite       <= reg_write_n;
            illegal        <= illegal_n;
            reg_write_addr <= addr_n;
            write_data     <= wd_n;
            carry          <= carry_n;
            zero           <= zero_n;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] op1, op2;
    logic [4:0]  dest_addr;
    logic        busy, RegWrite, carry, zero, illegal;
    logic [4:0]  reg_write_addr;
    logic [31:0] write_data;

    int n_checks = 0;
    int n_fails  = 0;

    exec_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .op1(op1), .op2(op2), .dest_addr(dest_addr),
        .busy(busy), .RegWrite(RegWrite), .reg_write_addr(reg_write_addr),
        .write_data(write_data), .carry(carry), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: result, carry flag, write-back delay, legality
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic c, output int d, output logic ill);
        logic [32:0] wide;
        int sh;
        sh  = int'(b[4:0]);
        res = 32'h0; c = 1'b0; d = 0; ill = 1'b0;
        case (op)
            4'd0: begin wide = 33'(a) + 33'(b); res = wide[31:0]; c = wide[32]; end
            4'd1: begin wide = 33'(a) - 33'(b); res = wide[31:0]; c = (a >= b); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~a;
            4'd6: begin res = a << sh; c = (sh == 0) ? 1'b0 : a[32-sh]; d = sh; end
            4'd7: begin res = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; d = sh; end
            4'd8: begin res = 32'($signed(a) >>> sh); c = (sh == 0) ? 1'b0 : a[sh-1]; d = sh; end
            4'd9: begin res = 32'(64'(a) * 64'(b)); d = 32; end
            default: ill = 1'b1;
        endcase
    endtask

    // Issue one operation and check every cycle up to the one after write-back.
    // poke_at > 0 pulses a competing start in that busy cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dst, input int poke_at);
        logic [31:0] res;
        logic c, ill;
        int d;
        model(op, a, b, res, c, d, ill);
        @(negedge clk);
        start = 1'b1; alu_op = op; op1 = a; op2 = b; dest_addr = dst;
        for (int i = 1; i <= d + 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            op1 = $urandom; op2 = $urandom; alu_op = 4'($urandom); dest_addr = 5'($urandom);
            if (i == poke_at) begin
                start = 1'b1; alu_op = 4'd0; op1 = 32'd1; op2 = 32'd1;
            end
            if (i <= d) begin
                check("busy_during", 32'(busy), 32'd1);
                check("no_early_wb", 32'(RegWrite), 32'd0);
            end else if (i == d + 1) begin
                check("busy_wb", 32'(busy), 32'd1);
                check("regwrite", 32'(RegWrite), 32'(!ill));
                check("illegal", 32'(illegal), 32'(ill));
                if (!ill) begin
                    check("wb_addr", 32'(reg_write_addr), 32'(dst));
                    check("wb_data", write_data, res);
                    check("carry", 32'(carry), 32'(c));
                    check("zero", 32'(zero), 32'(res == 32'h0));
                end
            end else begin
                check("busy_after", 32'(busy), 32'd0);
                check("wb_cleared", 32'(RegWrite), 32'd0);
                check("illegal_cleared", 32'(illegal), 32'd0);
            end
        end
        start = 1'b0;
        if (poke_at > 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("no_second_wb", 32'(RegWrite), 32'd0);
            end
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; alu_op = '0; op1 = '0; op2 = '0; dest_addr = '0;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_addr", 32'(reg_write_addr), 32'd0);

        // Directed cases from the plan
        run_op(4'd0, 32'd5, 32'd7, 5'd1, 0);
        run_op(4'd1, 32'd3, 32'd3, 5'd4, 0);
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd5, 0);
        run_op(4'd8, 32'h8000_0000, 32'd4, 5'd3, 0);
        run_op(4'd6, 32'd1, 32'd0, 5'd6, 0);
        run_op(4'd9, 32'h0000_2110, 32'd3, 5'd2, 5);
        run_op(4'd12, 32'd9, 32'd9, 5'd7, 0);
        run_op(4'd1, 32'd2, 32'd5, 5'd0, 0);
        run_op(4'd7, 32'hF000_000F, 32'd31, 5'd8, 0);
        run_op(4'd6, 32'hC000_0001, 32'd1, 5'd9, 0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd0, 5'd10, 0);

        // Reset in the middle of a multiply aborts it with no write-back
        @(negedge clk);
        start = 1'b1; alu_op = 4'd9; op1 = 32'd7; op2 = 32'd9; dest_addr = 5'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", write_data, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("midrst_no_wb", 32'(RegWrite), 32'd0);
        end

        // Random operations
        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (k % 4 == 0) rb = 32'($urandom_range(0, 3));
            run_op(rop, ra, rb, 5'($urandom), (k % 5 == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Multi-cycle execute stage that sits directly downstream of register_file.
- Consumes the two read operands (data1/data2 driven onto op1/op2) plus a 5-bit destination address.
- Computes an ALU, shift or multiply result, then issues a one-cycle write-back request (RegWrite, reg_write_addr, write_data) that drives the register file's write port.
- Shifts run one bit per cycle and multiply runs one partial product per cycle, so the block uses a start/busy handshake.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; it must match the register file.
- MUL_CYCLES, 32, number of shift-add iterations for MUL. Must equal WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- alu_op  input  4  operation code, sampled with start.
- op1  input  32  operand 1, from register_file data1.
- op2  input  32  operand 2, from register_file data2; shift amount is op2[4:0].
- dest_addr  input  5  destination register, sampled with start.
- busy  output  1  operation in progress.
- RegWrite  output  1  one-cycle write-back strobe to register_file.
- reg_write_addr  output  5  destination register for write-back.
- write_data  output  32  result.
- carry  output  1  carry flag, valid while RegWrite=1.
- zero  output  1  set when write_data==0, valid while RegWrite=1.
- illegal  output  1  one-cycle pulse for an undefined opcode.

Behaviour:
- Reset (rst=1 at any clk edge):
  - State goes to IDLE.
  - busy, RegWrite, illegal, carry and zero go to 0.
  - write_data and reg_write_addr go to 0.
  - Any in-flight operation is aborted with no write-back.
  - rst has priority over start.
- Opcodes:
  - 0 ADD, 1 SUB (op1-op2), 2 AND, 3 OR, 4 XOR, 5 NOT (~op1; op2 ignored).
  - 6 SLL, 7 SRL, 8 SRA (each by op2[4:0]).
  - 9 MUL: unsigned, low 32 bits kept.
  - 10-15 are illegal.
- Acceptance:
  - start=1 with busy=0 at edge E0 latches alu_op, op1, op2 and dest_addr.
  - Operands may change after E0.
  - start while busy=1 is ignored (not queued).
- States: IDLE, SHIFT, MUL, WB.
- IDLE:
  - Single-cycle op or shamt=0 goes to WB, with the result registered at E0.
  - Shift with shamt>0 goes to SHIFT, count=shamt.
  - MUL goes to MUL with acc=0 and count=MUL_CYCLES.
  - Illegal opcode goes to WB with the write-back suppressed.
- SHIFT: each edge shifts the working value one bit and decrements count. When count reaches 0 the result goes to write_data and the state moves to WB.
  - SLL/SRL fill with 0.
  - SRA fills with bit 31.
- MUL: each edge does acc += multiplicand if multiplier[0]=1, then multiplicand <<= 1 and multiplier >>= 1, then count is decremented. After 32 iterations the state moves to WB.
- WB (exactly one cycle):
  - RegWrite=1 with write_data and reg_write_addr valid.
  - Next state is IDLE.
  - For an illegal opcode, RegWrite=0 and illegal=1 instead.
- Timing:
  - busy=1 from the cycle after E0 through the WB cycle inclusive.
  - busy=0 in the cycle after WB, so a new start may be sampled at the edge ending WB+1.
- Write-back delay D (RegWrite is high in the cycle after edge E0+D):
  - D=0 for ALU ops, NOT, shifts with shamt=0, and illegal.
  - D=shamt for shifts.
  - D=32 for MUL.
- Flags:
  - ADD: carry = bit-32 carry-out.
  - SUB: computed as op1 + ~op2 + 1; carry = carry-out (1 means no borrow).
  - Shifts: carry = last bit shifted out; 0 when shamt=0.
  - Logic ops and MUL: carry = 0.
  - zero = (result==0) for all ops.
- Outputs hold:
  - write_data, reg_write_addr, carry and zero hold their last values outside WB.
  - RegWrite and illegal are 0 outside WB.
- dest_addr=0 is written back normally; the register file decides the effect.
- A 1-bit shift of a 32-bit value completes in exactly shamt cycles. shamt=31 is legal.

Test Plan:
- Reset: rst=1 for 2 cycles → busy=0, RegWrite=0, write_data=0, illegal=0.
- ADD op1=5, op2=7, dest=1, start for 1 cycle → the next cycle has busy=1, RegWrite=1, reg_write_addr=1, write_data=12, carry=0, zero=0. The cycle after that has busy=0.
- SUB op1=3, op2=3 → write_data=0, zero=1, carry=1. ADD op1=0xFFFFFFFF, op2=1 → write_data=0, carry=1, zero=1.
- SRA op1=0x80000000, op2=4, dest=3 → busy for 5 cycles; RegWrite in the cycle after E0+4 with write_data=0xF8000000 and carry=0. SLL op1=1, op2=0 → write_data=1 after D=0.
- MUL op1=0x00002110, op2=3, dest=2 → RegWrite exactly 32 edges after E0, write_data=0x00006330. A start pulsed at cycle 5 of the MUL is ignored and produces no second write-back.
- Reset mid-MUL at E0+10 → busy=0 the next cycle, and no RegWrite occurs through E0+40. alu_op=12 → illegal=1 and RegWrite=0 for one cycle.
